wb_arbiter: RTL

- Writeback arbiter directly upstream of the register file; the register file's only write port is fed from this block.
- Accepts results from two execution sources through valid/ready handshakes: port A (integer ALU) and port B (load/multiply unit).
- Buffers each source in its own FIFO and issues at most one register write per cycle, granting round-robin.
- Its wb_we, wb_rd and wb_data outputs drive the register file's reg_write, Write_reg and Write_Data inputs.

---
 rtl/wb_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two buffered result sources, round-robin onto
// the single register-file write port.
module wb_arbiter #(
   parameter int ADDR  = 5,
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [ADDR-1:0]  a_rd,
   input  logic [WIDTH-1:0] a_data,
   input  logic [TAG_W-1:0] a_tag,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [ADDR-1:0]  b_rd,
   input  logic [WIDTH-1:0] b_data,
   input  logic [TAG_W-1:0] b_tag,
   output logic             wb_we,
   output logic [ADDR-1:0]  wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_fire
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = ADDR + WIDTH + TAG_W;

   logic [EW-1:0]    r_mem_a [DEPTH];
   logic [EW-1:0]    r_mem_b [DEPTH];
   logic [PW:0]      r_wp_a, r_rp_a;
   logic [PW:0]      r_wp_b, r_rp_b;
   logic             r_prio_a;
   logic             r_we, r_fire;
   logic [ADDR-1:0]  r_rd;
   logic [WIDTH-1:0] r_data;
   logic [TAG_W-1:0] r_tag;

   logic             w_empty_a, w_full_a;
   logic             w_empty_b, w_full_b;
   logic             w_push_a, w_push_b;
   logic             w_grant_a, w_grant_b, w_pop;
   logic [EW-1:0]    w_head;
   logic [ADDR-1:0]  w_rd;
   logic [WIDTH-1:0] w_data;
   logic [TAG_W-1:0] w_tag;

   assign w_empty_a = (r_wp_a == r_rp_a);
   assign w_empty_b = (r_wp_b == r_rp_b);
   assign w_full_a  = (r_wp_a == {~r_rp_a[PW], r_rp_a[PW-1:0]});
   assign w_full_b  = (r_wp_b == {~r_rp_b[PW], r_rp_b[PW-1:0]});

   assign a_ready  = ~w_full_a;
   assign b_ready  = ~w_full_b;
   assign w_push_a = a_valid & a_ready;
   assign w_push_b = b_valid & b_ready;

   // Priority only matters when both sources hold an entry
   assign w_grant_a = ~w_empty_a & (w_empty_b | r_prio_a);
   assign w_grant_b = ~w_empty_b & ~w_grant_a;
   assign w_pop     = w_grant_a | w_grant_b;

   assign w_head = w_grant_a ? r_mem_a[r_rp_a[PW-1:0]]
                             : r_mem_b[r_rp_b[PW-1:0]];
   assign {w_rd, w_data, w_tag} = w_head;

   always_ff @(posedge clk) begin
      if (w_push_a) r_mem_a[r_wp_a[PW-1:0]] <= {a_rd, a_data, a_tag};
      if (w_push_b) r_mem_b[r_wp_b[PW-1:0]] <= {b_rd, b_data, b_tag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp_a <= '0;
         r_rp_a <= '0;
         r_wp_b <= '0;
         r_rp_b <= '0;
      end else if (flush) begin
         r_wp_a <= '0;
         r_rp_a <= '0;
         r_wp_b <= '0;
         r_rp_b <= '0;
      end else begin
         if (w_push_a)  r_wp_a <= r_wp_a + 1'b1;
         if (w_push_b)  r_wp_b <= r_wp_b + 1'b1;
         if (w_grant_a) r_rp_a <= r_rp_a + 1'b1;
         if (w_grant_b) r_rp_b <= r_rp_b + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio_a <= 1'b1;
      end else if (flush) begin
         r_prio_a <= 1'b1;
      end else if (!w_empty_a && !w_empty_b) begin
         r_prio_a <= ~r_prio_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we   <= 1'b0;
         r_fire <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
         r_tag  <= '0;
      end else if (flush) begin
         r_we   <= 1'b0;
         r_fire <= 1'b0;
      end else if (w_pop) begin
         r_we   <= (w_rd != '0);
         r_fire <= 1'b1;
         r_rd   <= w_rd;
         r_data <= w_data;
         r_tag  <= w_tag;
      end else begin
         r_we   <= 1'b0;
         r_fire <= 1'b0;
      end
   end

   assign wb_we   = r_we;
   assign wb_fire = r_fire;
   assign wb_rd   = r_rd;
   assign wb_data = r_data;
   assign wb_tag  = r_tag;
endmodule
